mc_core: RTL and testbench
==========================

Name: mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle 9-bit core.
- Same 9-bit instruction format, decoded as opcode [8:6], rd [5:3], rs/imm3 [2:0]. Data width and PC width are generalised.
- Adds a start/done protocol, a variable-latency data-memory handshake, relative branches, register-indirect jump and a retired-instruction counter.
- Sits between a synchronous instruction ROM and a data memory with a ready handshake, at the top of the ISA demo.

Parameters:
DATA_W, 8, register/ALU/data-memory word width (>=4)
PC_W, 6, program counter / instruction address width
DMEM_AW, 8, data-memory address width; addresses are r[rs][DMEM_AW-1:0], zero-extended if DATA_W < DMEM_AW
CNT_W, 16, retired-instruction counter width
START_PC, 0, PC value loaded on reset and on start

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins execution from START_PC
imem_addr  out  PC_W  instruction address, driven in FETCH
imem_rdata  in  9  instruction word, valid the cycle after imem_addr
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
dmem_addr  out  DMEM_AW  data address
dmem_wdata  out  DATA_W  store data
dmem_ready  in  1  access complete; load data valid this cycle
dmem_rdata  in  DATA_W  load data
busy  out  1  high in every state except IDLE and HALT
done  out  1  high in HALT
pc  out  PC_W  current PC
retired  out  CNT_W  instructions retired since last start; HALT counts

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, pc=START_PC, all 8 registers=0, retired=0, ir=0.
  - dmem_req=0, dmem_we=0, busy=0, done=0.
  - Takes effect mid-access: dmem_req drops the cycle after reset is sampled, and no register write occurs.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
  - IDLE --start--> FETCH. On that edge: pc=START_PC, retired=0.
  - FETCH: imem_addr=pc --> DECODE.
  - DECODE: ir <= imem_rdata --> EXEC.
  - EXEC: execute ir.
    - LD/ST --> MEM.
    - HALT --> HALT.
    - Otherwise --> FETCH.
  - MEM: dmem_req=1; dmem_we, dmem_addr and dmem_wdata held stable until dmem_ready.
    - On ready: LD writes rd <= dmem_rdata; pc <= pc+1; retired++; --> FETCH.
    - dmem_ready outside MEM is ignored.
  - HALT: done=1. start --> FETCH with pc=START_PC and retired=0; registers are retained.
- Latency: ALU, branch and jump instructions take 3 cycles. LD/ST take 3 + N cycles, where N >= 1 is the number of MEM cycles up to and including the ready cycle.
- start is ignored while busy.
- Opcodes. All arithmetic is modulo 2^DATA_W; imm3 is zero-extended unless stated. PC increments and branches use the current pc and wrap modulo 2^PC_W.
  - 0 ADD: rd=rd+rs
  - 1 SUB: rd=rd-rs
  - 2 XOR: rd=rd^rs
  - 3 ADDI: rd=rd+imm3
  - 4 LD: rd=mem[rs]
  - 5 ST: mem[rs]=rd
  - 6 BNZ: if rd!=0 then pc=pc+sext(imm3) (range -4..+3), else pc=pc+1. Offset 0 with rd!=0 is a legal spin.
  - 7 SYS:
    - imm3=0: HALT; pc is unchanged.
    - Otherwise JR: pc=rd[PC_W-1:0], zero-extended if DATA_W < PC_W.
- The register write and the pc update commit on the EXEC (or MEM-ready) edge. retired increments on the same edge.
- No hardwired zero register.
- retired saturates at all-ones.

Decomposition:
- Package core_pkg holds:
  - opcode enum (OP_ADD..OP_SYS) and state enum (IDLE..HALT);
  - field-slice localparams (OPC_HI=8, RD_LO=3, IMM_W=3);
  - SYS_HALT=3'd0.
- Sub-module core_regfile: 8 x DATA_W, two combinational read ports, one synchronous write port, cleared on reset. Reused for register reads in DECODE/EXEC.

Test Plan:
- ADDI r1,5; ADDI r2,3; ADD r1,r2; SUB r2,r1; HALT -> r1=8, r2=0xFB (DATA_W=8), done=1, retired=5, 15 cycles from start to done.
- LD r3,[r4] with r4=0x10, mem[0x10]=0xA5, dmem_ready delayed 3 cycles -> dmem_req high exactly 4 cycles with dmem_addr=0x10 stable, r3=0xA5, instruction takes 7 cycles.
- Countdown: ADDI r1,3; loop SUB r1,r2 (r2=1); BNZ r1,-1; HALT -> BNZ taken twice, not taken once, r1=0, retired=8.
- ADDI r5,7; JR r5 with pc at 2^PC_W-1 path, and BNZ +3 at pc=62 (PC_W=6) -> pc=7 after JR; pc wraps to 1 after the branch.
- reset driven low while in MEM with dmem_ready=0 -> next cycle dmem_req=0, busy=0, no register written, pc=START_PC.
- start pulsed while busy -> ignored. start pulsed in HALT -> retired resets to 0, registers keep their values, execution restarts at START_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and instruction-field constants for the multi-cycle 9-bit ISA core.
package core_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_ADDI = 3'd3,
        OP_LD   = 3'd4,
        OP_ST   = 3'd5,
        OP_BNZ  = 3'd6,
        OP_SYS  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam int INSTR_W  = 9;
    localparam int OPC_HI   = 8;
    localparam int OPC_LO   = 6;
    localparam int RD_HI    = 5;
    localparam int RD_LO    = 3;
    localparam int RS_HI    = 2;
    localparam int RS_LO    = 0;
    localparam int IMM_W    = 3;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;

    localparam logic [IMM_W-1:0] SYS_HALT = 3'd0;

endpackage

// File: rtl/core_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous write port.
// All entries clear on synchronous active-low reset.
module core_regfile
    import core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_dat,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_dat,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_dat = regs_q[ra_addr];
    assign rb_dat = regs_q[rb_addr];

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 9-bit ISA core: FETCH/DECODE/EXEC (+MEM for loads/stores) with start/done control.
// Data accesses stall in MEM until dmem_ready; ALU/branch/jump take 3 cycles, LD/ST 3+N.
module mc_core
    import core_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 6,
    parameter int DMEM_AW  = 8,
    parameter int CNT_W    = 16,
    parameter int START_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ready,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               busy,
    output logic               done,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   retired
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]     retired_q, retired_d;

    opcode_e              op;
    logic [REG_AW-1:0]    rd_idx;
    logic [REG_AW-1:0]    rs_idx;
    logic [IMM_W-1:0]     imm;
    logic signed [IMM_W-1:0] br_off;

    logic [DATA_W-1:0]    rd_val, rs_val, rf_wd;
    logic                 rf_we;

    logic [PC_W-1:0]      pc_inc, pc_br, pc_jr;
    logic [CNT_W-1:0]     retired_inc;

    assign op     = opcode_e'(ir_q[OPC_HI:OPC_LO]);
    assign rd_idx = ir_q[RD_HI:RD_LO];
    assign rs_idx = ir_q[RS_HI:RS_LO];
    assign imm    = ir_q[RS_HI:RS_LO];
    assign br_off = $signed(imm);

    core_regfile #(
        .DATA_W (DATA_W)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rd_idx),
        .ra_dat  (rd_val),
        .rb_addr (rs_idx),
        .rb_dat  (rs_val),
        .wr_en   (rf_we),
        .wr_addr (rd_idx),
        .wr_dat  (rf_wd)
    );

    // Size casts both zero-extend and truncate, covering either width ordering.
    assign pc_inc      = pc_q + PC_W'(1);
    assign pc_br       = pc_q + PC_W'(br_off);
    assign pc_jr       = PC_W'(rd_val);
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        rf_we     = 1'b0;
        rf_wd     = rd_val;
        dmem_req  = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = FETCH;
                    pc_d      = PC_W'(START_PC);
                    retired_d = '0;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                ir_d    = imem_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                state_d   = FETCH;
                pc_d      = pc_inc;
                retired_d = retired_inc;
                case (op)
                    OP_ADD: begin
                        rf_we = 1'b1;
                        rf_wd = rd_val + rs_val;
                    end
                    OP_SUB: begin
                        rf_we = 1'b1;
                        rf_wd = rd_val - rs_val;
                    end
                    OP_XOR: begin
                        rf_we = 1'b1;
                        rf_wd = rd_val ^ rs_val;
                    end
                    OP_ADDI: begin
                        rf_we = 1'b1;
                        rf_wd = rd_val + DATA_W'(imm);
                    end
                    OP_LD, OP_ST: begin
                        // Memory ops retire and advance pc only once the access completes.
                        state_d   = MEM;
                        pc_d      = pc_q;
                        retired_d = retired_q;
                    end
                    OP_BNZ: begin
                        if (rd_val != '0) begin
                            pc_d = pc_br;
                        end
                    end
                    OP_SYS: begin
                        if (imm == SYS_HALT) begin
                            state_d = HALT;
                            pc_d    = pc_q;
                        end else begin
                            pc_d = pc_jr;
                        end
                    end
                    default: begin
                        state_d = FETCH;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d   = FETCH;
                    pc_d      = pc_inc;
                    retired_d = retired_inc;
                    if (op == OP_LD) begin
                        rf_we = 1'b1;
                        rf_wd = dmem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= PC_W'(START_PC);
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Registers are stable throughout MEM, so address/data stay held until ready.
    assign dmem_we    = (state_q == MEM) && (op == OP_ST);
    assign dmem_addr  = DMEM_AW'(rs_val);
    assign dmem_wdata = rd_val;

    assign imem_addr = pc_q;
    assign busy      = (state_q != IDLE) && (state_q != HALT);
    assign done      = (state_q == HALT);
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: ALU, load/store with wait states, branches, jumps, reset and start handling.
module tb_mc_core;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  imem_addr;
    logic [8:0]  imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic        busy, done;
    logic [5:0]  pc;
    logic [15:0] retired;

    int checks = 0;
    int failures = 0;

    logic [8:0] imem [64];
    logic [7:0] dmem [256];
    int         dly = 0;
    int         wcnt = 0;

    // Observations recorded by the monitor processes.
    int         ld_cyc = 0, st_cyc = 0, ld_bad = 0, st_bad = 0;
    logic [7:0] st_addr = '0, st_data = '0;
    int         st_cnt = 0;

    mc_core dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem[imem_addr];

    assign dmem_ready = dmem_req && (wcnt == dly);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_req && !dmem_ready) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (dmem_req && dmem_we && dmem_ready) begin
            st_addr <= dmem_addr;
            st_data <= dmem_wdata;
            st_cnt  <= st_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (dmem_req) begin
            if (dmem_we) begin
                st_cyc <= st_cyc + 1;
                if (dmem_addr !== 8'h11 || dmem_wdata !== 8'hA5) st_bad <= st_bad + 1;
            end else begin
                ld_cyc <= ld_cyc + 1;
                if (dmem_addr !== 8'h10) ld_bad <= ld_bad + 1;
            end
        end
    end

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 9'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b req=%b we=%b expected all 0", busy, done, dmem_req, dmem_we);
        end
        checks++;
        if (pc !== 6'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL reset_state pc=%0d retired=%0d expected 0 0", pc, retired);
        end
        checks++;
        if (dut.u_rf.regs_q[1] !== 8'h0 || dut.u_rf.regs_q[7] !== 8'h0) begin
            failures++;
            $display("FAIL reset_regs r1=%h r7=%h expected 00 00", dut.u_rf.regs_q[1], dut.u_rf.regs_q[7]);
        end
    endtask

    task automatic test_alu();
        int cyc;
        do_reset();
        clear_imem();
        imem[0] = enc(3'd3, 3'd1, 3'd5);
        imem[1] = enc(3'd3, 3'd2, 3'd3);
        imem[2] = enc(3'd0, 3'd1, 3'd2);
        imem[3] = enc(3'd1, 3'd2, 3'd1);
        imem[4] = enc(3'd7, 3'd0, 3'd0);
        run(cyc);
        checks++;
        if (cyc != 15) begin
            failures++;
            $display("FAIL alu_cycles got=%0d expected=15", cyc);
        end
        checks++;
        if (dut.u_rf.regs_q[1] !== 8'h08 || dut.u_rf.regs_q[2] !== 8'hFB) begin
            failures++;
            $display("FAIL alu_regs r1=%h r2=%h expected 08 FB", dut.u_rf.regs_q[1], dut.u_rf.regs_q[2]);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || retired !== 16'd5 || pc !== 6'd4) begin
            failures++;
            $display("FAIL alu_halt done=%b busy=%b retired=%0d pc=%0d expected 1 0 5 4", done, busy, retired, pc);
        end
    endtask

    task automatic test_load_store();
        int cyc, ld0, st0, lb0, sb0;
        do_reset();
        clear_imem();
        dmem[8'h10] = 8'hA5;
        dly = 3;
        imem[0] = enc(3'd3, 3'd4, 3'd7);
        imem[1] = enc(3'd0, 3'd4, 3'd4);
        imem[2] = enc(3'd3, 3'd4, 3'd2);
        imem[3] = enc(3'd4, 3'd3, 3'd4);
        imem[4] = enc(3'd3, 3'd4, 3'd1);
        imem[5] = enc(3'd5, 3'd3, 3'd4);
        imem[6] = enc(3'd7, 3'd0, 3'd0);
        ld0 = ld_cyc; st0 = st_cyc; lb0 = ld_bad; sb0 = st_bad;
        run(cyc);
        checks++;
        if (cyc != 29) begin
            failures++;
            $display("FAIL ldst_cycles got=%0d expected=29", cyc);
        end
        checks++;
        if (ld_cyc - ld0 != 4 || st_cyc - st0 != 4) begin
            failures++;
            $display("FAIL ldst_req_len ld=%0d st=%0d expected 4 4", ld_cyc - ld0, st_cyc - st0);
        end
        checks++;
        if (ld_bad != lb0 || st_bad != sb0) begin
            failures++;
            $display("FAIL ldst_addr_stable ld_bad=%0d st_bad=%0d expected 0 0", ld_bad - lb0, st_bad - sb0);
        end
        checks++;
        if (dut.u_rf.regs_q[3] !== 8'hA5 || dut.u_rf.regs_q[4] !== 8'h11) begin
            failures++;
            $display("FAIL ldst_regs r3=%h r4=%h expected A5 11", dut.u_rf.regs_q[3], dut.u_rf.regs_q[4]);
        end
        checks++;
        if (st_addr !== 8'h11 || st_data !== 8'hA5 || retired !== 16'd7) begin
            failures++;
            $display("FAIL ldst_store addr=%h data=%h retired=%0d expected 11 A5 7", st_addr, st_data, retired);
        end
    endtask

    task automatic test_countdown();
        int cyc;
        do_reset();
        clear_imem();
        dly = 0;
        imem[0] = enc(3'd3, 3'd2, 3'd1);
        imem[1] = enc(3'd7, 3'd0, 3'd0);
        run(cyc);
        clear_imem();
        imem[0] = enc(3'd3, 3'd1, 3'd3);
        imem[1] = enc(3'd1, 3'd1, 3'd2);
        imem[2] = enc(3'd6, 3'd1, 3'd7);
        imem[3] = enc(3'd7, 3'd0, 3'd0);
        run(cyc);
        checks++;
        if (cyc != 24 || retired !== 16'd8) begin
            failures++;
            $display("FAIL countdown_len cycles=%0d retired=%0d expected 24 8", cyc, retired);
        end
        checks++;
        if (dut.u_rf.regs_q[1] !== 8'h00 || dut.u_rf.regs_q[2] !== 8'h01 || pc !== 6'd3) begin
            failures++;
            $display("FAIL countdown_state r1=%h r2=%h pc=%0d expected 00 01 3",
                     dut.u_rf.regs_q[1], dut.u_rf.regs_q[2], pc);
        end
    endtask

    task automatic test_jump_wrap();
        int cyc;
        do_reset();
        clear_imem();
        imem[0] = enc(3'd3, 3'd5, 3'd7);
        imem[1] = enc(3'd7, 3'd5, 3'd1);
        imem[7] = enc(3'd3, 3'd7, 3'd2);
        imem[8] = enc(3'd1, 3'd6, 3'd7);
        imem[9] = enc(3'd7, 3'd0, 3'd0);
        run(cyc);
        checks++;
        if (cyc != 15 || pc !== 6'd9 || dut.u_rf.regs_q[7] !== 8'h02 || dut.u_rf.regs_q[6] !== 8'hFE) begin
            failures++;
            $display("FAIL jr_target cycles=%0d pc=%0d r7=%h r6=%h expected 15 9 02 FE",
                     cyc, pc, dut.u_rf.regs_q[7], dut.u_rf.regs_q[6]);
        end
        clear_imem();
        imem[0]  = enc(3'd7, 3'd6, 3'd1);
        imem[62] = enc(3'd6, 3'd6, 3'd3);
        imem[1]  = enc(3'd7, 3'd0, 3'd0);
        run(cyc);
        checks++;
        if (cyc != 9 || pc !== 6'd1 || retired !== 16'd3) begin
            failures++;
            $display("FAIL bnz_wrap cycles=%0d pc=%0d retired=%0d expected 9 1 3", cyc, pc, retired);
        end
    endtask

    task automatic test_reset_in_mem();
        int n;
        do_reset();
        clear_imem();
        dly = 50;
        imem[0] = enc(3'd3, 3'd1, 3'd4);
        imem[1] = enc(3'd4, 3'd2, 3'd1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (dmem_req !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmem_reach req=%b expected 1", dmem_req);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || pc !== 6'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL rstmem_ctrl req=%b busy=%b pc=%0d retired=%0d expected 0 0 0 0",
                     dmem_req, busy, pc, retired);
        end
        checks++;
        if (dut.u_rf.regs_q[2] !== 8'h00) begin
            failures++;
            $display("FAIL rstmem_nowrite r2=%h expected 00", dut.u_rf.regs_q[2]);
        end
        @(negedge clk);
        reset = 1'b1;
        dly = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmem_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_start_handling();
        int cyc;
        do_reset();
        clear_imem();
        imem[0] = enc(3'd3, 3'd1, 3'd5);
        imem[1] = enc(3'd3, 3'd2, 3'd3);
        imem[2] = enc(3'd0, 3'd1, 3'd2);
        imem[3] = enc(3'd1, 3'd2, 3'd1);
        imem[4] = enc(3'd7, 3'd0, 3'd0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(posedge clk);
            #1 cyc++;
            start = (cyc == 5 || cyc == 9);
        end
        start = 1'b0;
        checks++;
        if (cyc != 15 || retired !== 16'd5 || dut.u_rf.regs_q[1] !== 8'h08) begin
            failures++;
            $display("FAIL start_busy cycles=%0d retired=%0d r1=%h expected 15 5 08",
                     cyc, retired, dut.u_rf.regs_q[1]);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (retired !== 16'd0 || busy !== 1'b1 || pc !== 6'd0
            || dut.u_rf.regs_q[1] !== 8'h08 || dut.u_rf.regs_q[2] !== 8'hFB) begin
            failures++;
            $display("FAIL restart_state retired=%0d busy=%b pc=%0d r1=%h r2=%h expected 0 1 0 08 FB",
                     retired, busy, pc, dut.u_rf.regs_q[1], dut.u_rf.regs_q[2]);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(posedge clk);
            #1 cyc++;
        end
        checks++;
        if (cyc != 15 || retired !== 16'd5 || dut.u_rf.regs_q[1] !== 8'h0B || dut.u_rf.regs_q[2] !== 8'hF3) begin
            failures++;
            $display("FAIL restart_run cycles=%0d retired=%0d r1=%h r2=%h expected 15 5 0B F3",
                     cyc, retired, dut.u_rf.regs_q[1], dut.u_rf.regs_q[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 8'(i);
        clear_imem();
        test_reset();
        test_alu();
        test_load_store();
        test_countdown();
        test_jump_wrap();
        test_reset_in_mem();
        test_start_handling();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
